// File: rtl/alu_pkg.sv
// Shared definitions for the logical pipeline: function-select encoding and
// the width helper used for the occupancy counter.
package alu_pkg;

    // Function-select encoding applied when the upper-immediate mode is off.
    typedef enum logic [2:0] {
        LF_AND  = 3'b000,
        LF_OR   = 3'b001,
        LF_XOR  = 3'b010,
        LF_NOR  = 3'b011,
        LF_ANDN = 3'b100,
        LF_ORN  = 3'b101,
        LF_CLZ  = 3'b110,
        LF_CLO  = 3'b111
    } lf_e;

    // Bits needed to hold an occupancy value from 0 to depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/logical_core.sv
// Combinational logical unit: bitwise functions, leading-zero/one counts and
// the upper-immediate load.
// Build option: LOGICAL_PIPE_CLZ_EN enables the leading-run counters; without
// it, af 110/111 (with i=0) produce res=0 and flag illegal.
module logical_core
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int IMM_W = N / 2
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   af,
    input  logic         i,
    output logic [N-1:0] res,
    output logic         zero,
    output logic         illegal
);

`ifdef LOGICAL_PIPE_CLZ_EN
    // Length of the run of bit_val starting at the MSB, zero-extended to N.
    function automatic logic [N-1:0] lead_run(input logic [N-1:0] v, input logic bit_val);
        logic [N-1:0] run;
        logic         stop;
        run  = '0;
        stop = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (!stop) begin
                if (v[k] == bit_val) begin
                    run = run + N'(1);
                end else begin
                    stop = 1'b1;
                end
            end
        end
        return run;
    endfunction
`endif

    // Operation select; the immediate mode overrides the function code.
    always_comb begin
        res     = '0;
        illegal = 1'b0;
        if (i) begin
            res = b << (N - IMM_W);
        end else begin
            case (af)
                LF_AND:  res = a & b;
                LF_OR:   res = a | b;
                LF_XOR:  res = a ^ b;
                LF_NOR:  res = ~(a | b);
                LF_ANDN: res = a & ~b;
                LF_ORN:  res = a | ~b;
                LF_CLZ: begin
`ifdef LOGICAL_PIPE_CLZ_EN
                    res = lead_run(a, 1'b0);
`else
                    illegal = 1'b1;
`endif
                end
                LF_CLO: begin
`ifdef LOGICAL_PIPE_CLZ_EN
                    res = lead_run(a, 1'b1);
`else
                    illegal = 1'b1;
`endif
                end
            endcase
        end
        zero = (res == '0);
    end

endmodule

// File: rtl/logical_pipe.sv
// Pipelined logical unit: the operation is evaluated ahead of stage 0, later
// stages only carry the result. Bubble-collapsing valid/ready pipeline.
// Build option: LOGICAL_PIPE_CLZ_EN (passed through to logical_core).
//
// Handshake: an operation transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. The producer holds its inputs
// until accepted; res/zero/illegal stay stable while out_valid && !out_ready.
// flush drops everything in flight (and any offer in that cycle) at the next edge.
module logical_pipe
    import alu_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 2,
    parameter int IMM_W  = N / 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N-1:0]                 a,
    input  logic [N-1:0]                 b,
    input  logic [2:0]                   af,
    input  logic                         i,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N-1:0]                 res,
    output logic                         zero,
    output logic                         illegal,
    output logic [count_w(STAGES)-1:0]   count
);

    localparam int CW = count_w(STAGES);

    logic [N-1:0]      core_res;
    logic              core_zero;
    logic              core_ill;

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] st_zero;
    logic [STAGES-1:0] st_ill;
    logic [N-1:0]      st_res [STAGES];

    logic [STAGES-1:0] prev_valid;
    logic [STAGES-1:0] prev_zero;
    logic [STAGES-1:0] prev_ill;
    logic [N-1:0]      prev_res [STAGES];

    logic              accept;
    logic              retire;

    logical_core #(
        .N     (N),
        .IMM_W (IMM_W)
    ) u_core (
        .a       (a),
        .b       (b),
        .af      (af),
        .i       (i),
        .res     (core_res),
        .zero    (core_zero),
        .illegal (core_ill)
    );

    assign in_ready  = !flush && adv[0];
    assign accept    = in_valid && in_ready;
    assign out_valid = valid[STAGES-1];
    assign retire    = out_valid && out_ready;
    assign res       = st_res[STAGES-1];
    assign zero      = st_zero[STAGES-1];
    assign illegal   = st_ill[STAGES-1];

    // Stage k may move when some stage from k to the output has a hole, or the consumer takes the result.
    always_comb begin
        logic tail_full;
        tail_full = 1'b1;
        adv       = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            tail_full = tail_full & valid[k];
            adv[k]    = out_ready | ~tail_full;
        end
    end

    // Feed of each stage: the core output for stage 0, the previous stage otherwise.
    always_comb begin
        prev_valid = '0;
        prev_zero  = '0;
        prev_ill   = '0;
        for (int k = 0; k < STAGES; k++) begin
            prev_res[k] = '0;
        end
        prev_valid[0] = accept;
        prev_res[0]   = core_res;
        prev_zero[0]  = core_zero;
        prev_ill[0]   = core_ill;
        for (int k = 1; k < STAGES; k++) begin
            prev_valid[k] = valid[k-1];
            prev_res[k]   = st_res[k-1];
            prev_zero[k]  = st_zero[k-1];
            prev_ill[k]   = st_ill[k-1];
        end
    end

    // Stage valid bits: cleared by reset or flush, otherwise shifted where a stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid[k] <= prev_valid[k];
                end
            end
        end
    end

    // Stage payloads: only overwritten by a valid entry, so an idle output keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_zero <= '1;
            st_ill  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_res[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k] && prev_valid[k]) begin
                    st_res[k]  <= prev_res[k];
                    st_zero[k] <= prev_zero[k];
                    st_ill[k]  <= prev_ill[k];
                end
            end
        end
    end

    // Occupancy: up on accept only, down on retire only, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_logical_pipe.sv
// Self-checking bench for logical_pipe (N=32, STAGES=3, IMM_W=16).
// Honours LOGICAL_PIPE_CLZ_EN for the expected leading-run results.
module tb_logical_pipe;

    localparam int N      = 32;
    localparam int STAGES = 3;
    localparam int IMM_W  = 16;
    localparam int W      = N + 2;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [2:0]    af;
    logic          i;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  res;
    logic          zero;
    logic          illegal;
    logic [1:0]    count;

    logical_pipe #(
        .N      (N),
        .STAGES (STAGES),
        .IMM_W  (IMM_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .af        (af),
        .i         (i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .zero      (zero),
        .illegal   (illegal),
        .count     (count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           cyc_q[$];
    logic [W-1:0] cur_exp;
    bit           check_lat;
    int           n_chk = 0;
    int           n_err = 0;
    int           n_acc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int lead_zeros(input logic [N-1:0] v);
        longint x;
        x = longint'(v);
        return N - $clog2(x + 1);
    endfunction

    function automatic logic [W-1:0] model(input logic [N-1:0] xa, input logic [N-1:0] xb,
                                           input logic [2:0] xaf, input logic xi);
        logic [N-1:0] r;
        logic         ill;
        r   = '0;
        ill = 1'b0;
        if (xi) begin
            r = {xb[IMM_W-1:0], {(N-IMM_W){1'b0}}};
        end else begin
            case (xaf)
                3'd0: r = xa & xb;
                3'd1: r = xa | xb;
                3'd2: r = xa ^ xb;
                3'd3: r = ~(xa | xb);
                3'd4: r = xa & ~xb;
                3'd5: r = xa | ~xb;
`ifdef LOGICAL_PIPE_CLZ_EN
                3'd6: r = N'(lead_zeros(xa));
                3'd7: r = N'(lead_zeros(~xa));
`else
                default: ill = 1'b1;
`endif
            endcase
        end
        return {r, (r == '0), ill};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        int           c;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_out: got res %0h with nothing expected (cycle %0d)", res, cyc);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check("result", {res, zero, illegal}, e);
                    if (check_lat) check("latency", cyc - c, STAGES);
                end
            end
            if (flush) begin
                exp_q.delete();
                cyc_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                cyc_q.push_back(cyc);
                n_acc++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept();
        int t;
        bit done;
        t    = 0;
        done = 1'b0;
        while (!done && t < 50) begin
            @(negedge clk);
            done = in_valid && in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        check("accept_timeout", done, 1);
    endtask

    task automatic drain(input int max_cyc);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < max_cyc) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'hFFFF_FFFF >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_op();
        a       = pick();
        b       = pick();
        af      = 3'($urandom_range(0, 7));
        i       = ($urandom_range(0, 3) == 0);
        cur_exp = model(a, b, af, i);
    endtask

    task automatic run_random(input int n_ops);
        int sent;
        int t;
        bit took;
        sent = 0;
        t    = 0;
        took = 1'b0;
        check_lat = 1'b0;
        in_valid  = 1'b0;
        while (sent < n_ops && t < 4000) begin
            flush = ($urandom_range(0, 99) < 3);
            if (!in_valid || took) begin
                if ($urandom_range(0, 99) < 70) begin
                    rand_op();
                    in_valid = 1'b1;
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(100);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [N-1:0] va;
        logic [N-1:0] vb;
        logic [2:0]   vaf;
        logic         vi;
        logic [N-1:0] vres;
        logic         vill;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    initial begin
        logic [N-1:0] frz;
        bit           have_frz;
        bit           took;
        int           acc0;

        vt[0]  = '{32'hAAAA5555, 32'h99996666, 3'd0, 1'b0, 32'h88884444, 1'b0};
        vt[1]  = '{32'hAAAA5555, 32'h99996666, 3'd1, 1'b0, 32'hBBBB7777, 1'b0};
        vt[2]  = '{32'hAAAA5555, 32'h99996666, 3'd2, 1'b0, 32'h33333333, 1'b0};
        vt[3]  = '{32'hAAAA5555, 32'h99996666, 3'd3, 1'b0, 32'h44448888, 1'b0};
        vt[4]  = '{32'hAAAA5555, 32'h99996666, 3'd4, 1'b0, 32'h22221111, 1'b0};
        vt[5]  = '{32'hAAAA5555, 32'h99996666, 3'd5, 1'b0, 32'hEEEEDDDD, 1'b0};
        vt[6]  = '{32'hAAAA5555, 32'h99996666, 3'd3, 1'b1, 32'h66660000, 1'b0};
`ifdef LOGICAL_PIPE_CLZ_EN
        vt[7]  = '{32'h0000FFFF, 32'h0, 3'd6, 1'b0, 32'h00000010, 1'b0};
        vt[8]  = '{32'h00000000, 32'h0, 3'd6, 1'b0, 32'h00000020, 1'b0};
        vt[9]  = '{32'hFFFFFFFF, 32'h0, 3'd7, 1'b0, 32'h00000020, 1'b0};
        vt[10] = '{32'hAAAA5555, 32'h0, 3'd7, 1'b0, 32'h00000001, 1'b0};
`else
        vt[7]  = '{32'h0000FFFF, 32'h0, 3'd6, 1'b0, 32'h00000000, 1'b1};
        vt[8]  = '{32'h00000000, 32'h0, 3'd6, 1'b0, 32'h00000000, 1'b1};
        vt[9]  = '{32'hFFFFFFFF, 32'h0, 3'd7, 1'b0, 32'h00000000, 1'b1};
        vt[10] = '{32'hAAAA5555, 32'h0, 3'd7, 1'b0, 32'h00000000, 1'b1};
`endif
        vt[11] = '{32'hFFFF0000, 32'h0000FFFF, 3'd0, 1'b0, 32'h00000000, 1'b0};
        vt[12] = '{32'h00000000, 32'hFFFF1234, 3'd6, 1'b1, 32'h12340000, 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        af        = '0;
        i         = 1'b0;
        cur_exp   = '0;
        check_lat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_res", res, 0);
        check("rst_zero", zero, 1);
        check("rst_illegal", illegal, 0);
        @(posedge clk);
        #1;

        // table vectors back-to-back, consumer always ready
        check_lat = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            a        = vt[k].va;
            b        = vt[k].vb;
            af       = vt[k].vaf;
            i        = vt[k].vi;
            cur_exp  = {vt[k].vres, (vt[k].vres == '0), vt[k].vill};
            in_valid = 1'b1;
            wait_accept();
        end
        in_valid = 1'b0;
        drain(30);

        // stall: consumer blocked, producer offers continuously
        check_lat = 1'b0;
        out_ready = 1'b0;
        acc0      = n_acc;
        have_frz  = 1'b0;
        took      = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (!in_valid || took) begin
                rand_op();
                in_valid = 1'b1;
            end
            @(negedge clk);
            took = in_valid && in_ready;
            if (out_valid && !have_frz) begin
                frz      = res;
                have_frz = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("stall_accepts", n_acc - acc0, STAGES);
        check("stall_count", count, STAGES);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_res_frozen", res, frz);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(30);

        // flush with two ops in flight and a new offer in the flush cycle
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rand_op();
            in_valid = 1'b1;
            wait_accept();
        end
        rand_op();
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_count", count, 0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("flush_count_after", count, 0);
        check("flush_queue_empty", exp_q.size(), 0);

        // asynchronous reset pulse mid-stream
        check_lat = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rand_op();
            in_valid = 1'b1;
            wait_accept();
        end
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_count", count, 0);
        #8;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_count_after", count, 0);
        a        = 32'hAAAA5555;
        b        = 32'h99996666;
        af       = 3'd2;
        i        = 1'b0;
        cur_exp  = model(a, b, af, i);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        drain(30);

        // randomized traffic with back-pressure and occasional flushes
        run_random(300);

        check("final_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
